uart_boot_loader: RTL and testbench

//  UART program loader and bus initiator. Receives a framed image from the host and writes it into BRAM as 32-bit

---
 rtl/uart_boot_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART program loader: receives an A5-framed image and issues 32-bit word stores while holding the core.
// Define UART_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_boot_loader #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned BASE_ADDR = 32'h0,
  parameter int unsigned MEM_WORDS = 'h901
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_txd_in,
  output logic        cpu_hold,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data,
  output logic        bus_store_enable,
  output logic        bus_is_sw,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_M1       = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1      = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  typedef enum logic [2:0] {
    StMagic, StLen0, StLen1, StData, StStore, StDone
`ifdef UART_BOOT_CHECKSUM_EN
    , StCsum
`endif
  } state_e;

  rx_state_e   rx_state;
  logic [1:0]  rx_sync;
  logic        rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_valid;
  logic        rx_ferr;

  state_e      state;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [31:0] word_q;
  logic [1:0]  byte_k;
  logic [15:0] len_full;
  logic [15:0] idx_inc;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign len_full = {rx_shift, len_q[7:0]};
  assign idx_inc  = idx_q + 16'd1;

  // Receiver: rx_shift holds the last byte while rx_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_txd_in};
      rx_prev  <= rx_sync[1];
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          if (rx_prev && !rx_sync[1]) begin
            rx_state <= RxStart;
            rx_cnt   <= HALF_M1;
          end
        end
        RxStart: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_sync[1]) begin
            rx_state <= RxIdle;
          end else begin
            rx_state <= RxData;
            rx_cnt   <= BIT_M1;
            rx_bit   <= '0;
          end
        end
        RxData: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_shift <= {rx_sync[1], rx_shift[7:1]};
            rx_cnt   <= BIT_M1;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RxStop;
          end
        end
        RxStop: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_state <= RxIdle;
            if (rx_sync[1]) rx_valid <= 1'b1;
            else            rx_ferr  <= 1'b1;
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // Frame FSM; bus outputs default to 0 and are raised only for the store cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= StMagic;
      len_q            <= '0;
      idx_q            <= '0;
      word_q           <= '0;
      byte_k           <= '0;
      cpu_hold         <= 1'b1;
      bus_address      <= '0;
      bus_data         <= '0;
      bus_store_enable <= 1'b0;
      bus_is_sw        <= 1'b0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q           <= '0;
`endif
    end else begin
      bus_address      <= '0;
      bus_data         <= '0;
      bus_store_enable <= 1'b0;
      bus_is_sw        <= 1'b0;
      if (state == StStore) begin
        idx_q <= idx_inc;
        if (idx_inc == len_q) begin
`ifdef UART_BOOT_CHECKSUM_EN
          state     <= StCsum;
`else
          state     <= StDone;
          cpu_hold  <= 1'b0;
          load_done <= 1'b1;
`endif
        end else begin
          state <= StData;
        end
      end else if (state != StDone && rx_ferr) begin
        load_err <= 1'b1;
        state    <= StMagic;
      end else if (state != StDone && rx_valid) begin
        case (state)
          StMagic: begin
            if (rx_shift == 8'hA5) begin
              state    <= StLen0;
              load_err <= 1'b0;
              idx_q    <= '0;
              byte_k   <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
              csum_q   <= '0;
`endif
            end
          end
          StLen0: begin
            len_q[7:0] <= rx_shift;
            state      <= StLen1;
          end
          StLen1: begin
            len_q <= len_full;
            if (len_full == 16'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
              state     <= StCsum;
`else
              state     <= StDone;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
`endif
            end else if ({16'd0, len_full} > MEM_WORDS) begin
              load_err <= 1'b1;
              state    <= StMagic;
            end else begin
              state <= StData;
            end
          end
          StData: begin
            word_q[{byte_k, 3'b000} +: 8] <= rx_shift;
            byte_k <= byte_k + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
            csum_q <= csum_q ^ rx_shift;
`endif
            if (byte_k == 2'd3) begin
              state            <= StStore;
              bus_store_enable <= 1'b1;
              bus_is_sw        <= 1'b1;
              bus_address      <= BASE_ADDR + {14'd0, idx_q, 2'b00};
              bus_data         <= {rx_shift, word_q[23:0]};
            end
          end
`ifdef UART_BOOT_CHECKSUM_EN
          StCsum: begin
            if (rx_shift == csum_q) begin
              state     <= StDone;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
              state    <= StMagic;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Table-driven bench for uart_boot_loader with a store scoreboard; 16 clocks per UART bit.
module tb_uart_boot_loader;

  localparam int unsigned BAUD = 115200;
  localparam int unsigned CLK_HZ = 16 * BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        txd = 1'b1;
  logic        cpu_hold;
  logic [31:0] bus_address;
  logic [31:0] bus_data;
  logic        bus_store_enable;
  logic        bus_is_sw;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;
  int idle_viol = 0;
  logic [63:0] sb_q[$];

  uart_boot_loader #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .BASE_ADDR(32'h0),
    .MEM_WORDS('h901)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_txd_in     (txd),
    .cpu_hold        (cpu_hold),
    .bus_address     (bus_address),
    .bus_data        (bus_data),
    .bus_store_enable(bus_store_enable),
    .bus_is_sw       (bus_is_sw),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_reset;
    int          n;
    logic [95:0] bytes;
    int          bad_idx;
    bit          has_csum;
    logic [7:0]  csum;
    int          ns;
    logic [31:0] sa0, sd0, sa1, sd1;
    logic        exp_done, exp_err, exp_hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit rst, int n, logic [95:0] by, int bad, bit hc, logic [7:0] cs,
                               int ns, logic [31:0] a0, logic [31:0] d0, logic [31:0] a1,
                               logic [31:0] d1, logic dn, logic er, logic hd);
    vec_t v;
    v.do_reset = rst; v.n = n; v.bytes = by; v.bad_idx = bad; v.has_csum = hc; v.csum = cs;
    v.ns = ns; v.sa0 = a0; v.sd0 = d0; v.sa1 = a1; v.sd1 = d1;
    v.exp_done = dn; v.exp_err = er; v.exp_hold = hd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Store monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_store_enable) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected: got addr %h data %h expected no store",
                 bus_address, bus_data);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if (bus_address !== e[63:32] || bus_data !== e[31:0] || bus_is_sw !== 1'b1) begin
          errors++;
          $display("FAIL store: got addr %h data %h sw %b expected addr %h data %h sw 1",
                   bus_address, bus_data, bus_is_sw, e[63:32], e[31:0]);
        end
      end
    end else if (bus_is_sw || bus_address != 32'd0 || bus_data != 32'd0) begin
      idle_viol++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    txd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txd = b[i];
      repeat (16) @(negedge clk);
    end
    txd = ~bad_stop;
    repeat (16) @(negedge clk);
    txd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    txd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic dn, input logic er, input logic hd);
    repeat (8) @(negedge clk);
    check({tag, " load_done"}, {31'd0, load_done}, {31'd0, dn});
    check({tag, " load_err"}, {31'd0, load_err}, {31'd0, er});
    check({tag, " cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hd});
    check({tag, " pending_stores"}, sb_q.size(), 32'd0);
    check({tag, " bus_idle_zero"}, idle_viol, 32'd0);
    sb_q.delete();
    idle_viol = 0;
  endtask

  initial begin
    vec_t v;
    vecs.push_back(mkv(1, 11, 96'hA5_02_00_78_56_34_12_EF_BE_AD_DE, -1, 1, 8'h2A,
                       2, 32'h0, 32'h12345678, 32'h4, 32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mkv(1, 9, 96'h00_FF_A5_01_00_44_33_22_11, -1, 1, 8'h44,
                       1, 32'h0, 32'h11223344, 0, 0, 1, 0, 0));
    // Input after completion is ignored.
    vecs.push_back(mkv(0, 7, 96'hA5_01_00_01_02_03_04, -1, 0, 8'h00,
                       0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 3, 96'hA5_02_09, -1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 3, 96'hA5_00_00, -1, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    // Largest accepted length: no error, still loading.
    vecs.push_back(mkv(1, 3, 96'hA5_01_09, -1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 5, 96'hA5_02_00_78_56, 4, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mkv(0, 7, 96'hA5_01_00_44_33_22_11, -1, 1, 8'h44,
                       1, 32'h0, 32'h11223344, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 7, 96'hA5_01_00_01_02_04_08, -1, 1, 8'h0F,
                       1, 32'h0, 32'h08040201, 0, 0, 1, 0, 0));
`ifdef UART_BOOT_CHECKSUM_EN
    vecs.push_back(mkv(1, 7, 96'hA5_01_00_01_02_04_08, -1, 1, 8'h0E,
                       1, 32'h0, 32'h08040201, 0, 0, 0, 1, 1));
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("reset load_done", {31'd0, load_done}, 32'd0);
    check("reset load_err", {31'd0, load_err}, 32'd0);
    check("reset bus_address", bus_address, 32'd0);
    check("reset bus_data", bus_data, 32'd0);
    check("reset bus_store_enable", {31'd0, bus_store_enable}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.do_reset) do_reset();
      if (v.ns > 0) sb_q.push_back({v.sa0, v.sd0});
      if (v.ns > 1) sb_q.push_back({v.sa1, v.sd1});
      for (int k = 0; k < v.n; k++) send_byte(v.bytes[8*(v.n-1-k) +: 8], k == v.bad_idx);
`ifdef UART_BOOT_CHECKSUM_EN
      if (v.has_csum) send_byte(v.csum, 1'b0);
`endif
      check_end($sformatf("vec%0d", i), v.exp_done, v.exp_err, v.exp_hold);
    end

    // Short low glitch mid-payload must not be taken as a start bit.
    do_reset();
    sb_q.push_back({32'h0, 32'hAABBCCDD});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    txd = 1'b0;
    repeat (4) @(negedge clk);
    txd = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'hDD, 0); send_byte(8'hCC, 0); send_byte(8'hBB, 0); send_byte(8'hAA, 0);
`ifdef UART_BOOT_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check_end("glitch", 1, 0, 0);

    // Reset mid-payload, then a fresh frame.
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h44, 0); send_byte(8'h33, 0);
    rst_n = 1'b0;
    #1;
    check("midrst cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst load_done", {31'd0, load_done}, 32'd0);
    check("midrst load_err", {31'd0, load_err}, 32'd0);
    check("midrst bus_data", bus_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb_q.push_back({32'h0, 32'hAABBCCDD});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hDD, 0); send_byte(8'hCC, 0); send_byte(8'hBB, 0); send_byte(8'hAA, 0);
`ifdef UART_BOOT_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check_end("midrst_reload", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
